// File: rtl/inst_axi_bridge_if.sv
// inst_axi_bridge_if: instruction SRAM-like fetch port plus AXI read address/data channels
interface inst_axi_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: read-only instruction fetch to single-beat in-order AXI reads, up to two in flight
module inst_axi_bridge (
  input logic               clk,
  input logic               resetn,
  inst_axi_bridge_if.master bus
);
  typedef enum logic {IDLE, ADDR} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_cnt, r_size;
  logic [31:0] r_addr, r_rdata;
  logic        r_dok;
  logic        w_addr_ok, w_arvalid, w_rready, w_r_hs, w_unused;
  always_comb begin
    w_addr_ok = resetn && bus.inst_sram_req && !bus.inst_sram_wr && r_state == IDLE && r_cnt < 2'd2;
    w_arvalid = resetn && r_state == ADDR;
    w_next    = w_addr_ok ? ADDR : (w_arvalid && bus.arready) ? IDLE : r_state;
  end
  // a captured word blocks further R beats until it has been handed out as data_ok
  assign w_rready = resetn && r_cnt != 2'd0 && !r_dok;
  assign w_r_hs   = bus.rvalid && w_rready;
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_dok   <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_rdata <= '0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_addr_ok} - {1'b0, r_dok};
      r_dok <= w_r_hs;
      if (w_addr_ok) begin
        r_addr <= bus.inst_sram_addr;
        r_size <= bus.inst_sram_size;
      end
      if (w_r_hs) r_rdata <= bus.rdata;
    end
  end
  assign bus.inst_sram_addr_ok = w_addr_ok;
  assign bus.inst_sram_data_ok = r_dok && resetn;
  assign bus.inst_sram_rdata   = r_rdata;
  assign bus.arid    = 4'd0;
  assign bus.araddr  = r_addr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, r_size};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = w_arvalid;
  assign bus.rready  = w_rready;
  assign w_unused = &{1'b0, bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rresp, bus.rlast};
endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed scenarios with an expected-word queue checked on every data_ok
module tb_inst_axi_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_exp;
  inst_axi_bridge_if bif();
  inst_axi_bridge dut (.clk(clk), .resetn(resetn), .bus(bif));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  always @(negedge clk) begin
    if (resetn && bif.inst_sram_data_ok === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected data_ok rdata=%h with nothing outstanding", bif.inst_sram_rdata);
      end else begin
        m_exp = exp_q.pop_front();
        if (bif.inst_sram_rdata !== m_exp) begin
          failures++;
          $display("FAIL sb_order rdata=%h expected %h", bif.inst_sram_rdata, m_exp);
        end
      end
    end
  end
  task automatic idle_inputs;
    bif.inst_sram_req = 0; bif.inst_sram_wr = 0; bif.inst_sram_size = 0; bif.inst_sram_addr = 0;
    bif.inst_sram_wstrb = 4'hF; bif.inst_sram_wdata = 32'hDEAD_BEEF;
    bif.arready = 0; bif.rid = 0; bif.rdata = 0; bif.rresp = 0; bif.rlast = 0; bif.rvalid = 0;
  endtask
  task automatic ar_accept(input logic [31:0] a);
    int n = 0;
    while (bif.arvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bif.arvalid !== 1'b1 || bif.araddr !== a) begin
      failures++;
      $display("FAIL ar_accept arvalid=%b araddr=%h expected 1/%h", bif.arvalid, bif.araddr, a);
    end
    bif.arready = 1;
    @(negedge clk);
    bif.arready = 0;
  endtask
  task automatic send_r(input logic [31:0] d, input logic [1:0] resp);
    int n = 0;
    bif.rvalid = 1; bif.rdata = d; bif.rresp = resp; bif.rlast = 1; bif.rid = 4'h5;
    #1;
    while (bif.rready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (bif.rready !== 1'b1) begin
      failures++;
      $display("FAIL r_handshake rready=%b expected 1 within 20 cycles", bif.rready);
    end
    @(negedge clk);
    bif.rvalid = 0;
  endtask
  task automatic test_reset;
    idle_inputs();
    resetn = 0;
    bif.inst_sram_req = 1; bif.inst_sram_addr = 32'h1C00_0000; bif.rvalid = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bif.inst_sram_addr_ok, bif.arvalid, bif.rready, bif.inst_sram_data_ok} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl addr_ok/arvalid/rready/data_ok=%b expected 0000",
               {bif.inst_sram_addr_ok, bif.arvalid, bif.rready, bif.inst_sram_data_ok});
    end
    checks++;
    if (bif.araddr !== 32'h0 || bif.arsize !== 3'd0 || bif.inst_sram_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs araddr=%h arsize=%h rdata=%h expected 0", bif.araddr, bif.arsize, bif.inst_sram_rdata);
    end
    idle_inputs();
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
  endtask
  task automatic test_single_fetch;
    bif.inst_sram_req = 1; bif.inst_sram_addr = 32'h1C00_0000; bif.inst_sram_size = 2'd2;
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL single_addr_ok got %b expected 1", bif.inst_sram_addr_ok); end
    exp_q.push_back(32'h0280_0C0C);
    @(negedge clk);
    bif.inst_sram_req = 0; bif.arready = 1;
    checks++;
    if (bif.arvalid !== 1'b1 || bif.araddr !== 32'h1C00_0000 || bif.arsize !== 3'd2) begin
      failures++;
      $display("FAIL single_ar arvalid=%b araddr=%h arsize=%h expected 1/1c000000/2", bif.arvalid, bif.araddr, bif.arsize);
    end
    checks++;
    if ({bif.arid, bif.arlen, bif.arburst, bif.arlock, bif.arcache, bif.arprot} !== {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
      failures++;
      $display("FAIL single_ar_fixed arid=%h arlen=%h arburst=%b arlock=%b arcache=%h arprot=%h",
               bif.arid, bif.arlen, bif.arburst, bif.arlock, bif.arcache, bif.arprot);
    end
    @(negedge clk);
    bif.arready = 0;
    checks++;
    if (bif.arvalid !== 1'b0) begin failures++; $display("FAIL single_ar_drop arvalid=%b expected 0", bif.arvalid); end
    @(negedge clk);
    bif.rvalid = 1; bif.rdata = 32'h0280_0C0C; bif.rresp = 0; bif.rlast = 1;
    #1;
    checks++;
    if (bif.rready !== 1'b1) begin failures++; $display("FAIL single_rready got %b expected 1", bif.rready); end
    @(negedge clk);
    bif.rvalid = 0; bif.rdata = 32'h1234_5678;
    checks++;
    if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_rdata !== 32'h0280_0C0C || bif.rready !== 1'b0) begin
      failures++;
      $display("FAIL single_data data_ok=%b rdata=%h rready=%b expected 1/02800c0c/0",
               bif.inst_sram_data_ok, bif.inst_sram_rdata, bif.rready);
    end
    @(negedge clk);
    checks++;
    if (dut.r_cnt !== 2'd0 || bif.inst_sram_data_ok !== 1'b0 || bif.inst_sram_rdata !== 32'h0280_0C0C) begin
      failures++;
      $display("FAIL single_after count=%0d data_ok=%b rdata=%h expected 0/0/02800c0c",
               dut.r_cnt, bif.inst_sram_data_ok, bif.inst_sram_rdata);
    end
  endtask
  task automatic test_backpressure;
    bif.inst_sram_req = 1; bif.inst_sram_addr = 32'h1C00_0010; bif.inst_sram_size = 2'd2;
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL bp_first_accept got %b expected 1", bif.inst_sram_addr_ok); end
    exp_q.push_back(32'h1111_0010);
    @(negedge clk);
    bif.inst_sram_addr = 32'h1C00_0014;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bif.arvalid !== 1'b1 || bif.araddr !== 32'h1C00_0010 || bif.inst_sram_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] arvalid=%b araddr=%h addr_ok=%b expected 1/1c000010/0",
                 i, bif.arvalid, bif.araddr, bif.inst_sram_addr_ok);
      end
      @(negedge clk);
    end
    bif.arready = 1;
    @(negedge clk);
    bif.arready = 0;
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1 || bif.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_reaccept addr_ok=%b arvalid=%b expected 1/0", bif.inst_sram_addr_ok, bif.arvalid);
    end
    exp_q.push_back(32'h2222_0014);
    @(negedge clk);
    bif.inst_sram_req = 0;
    ar_accept(32'h1C00_0014);
    send_r(32'h1111_0010, 2'b00);
    send_r(32'h2222_0014, 2'b00);
    repeat (2) @(negedge clk);
  endtask
  task automatic test_two_outstanding;
    bif.inst_sram_req = 1; bif.inst_sram_addr = 32'h1C00_0000;
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL two_accept0 got %b expected 1", bif.inst_sram_addr_ok); end
    exp_q.push_back(32'hAAAA_0000);
    @(negedge clk);
    bif.inst_sram_addr = 32'h1C00_0004; bif.arready = 1;
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b0) begin failures++; $display("FAIL two_busy got %b expected 0", bif.inst_sram_addr_ok); end
    @(negedge clk);
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL two_accept1 got %b expected 1", bif.inst_sram_addr_ok); end
    exp_q.push_back(32'hBBBB_0004);
    @(negedge clk);
    bif.inst_sram_addr = 32'h1C00_0008;
    checks++;
    if (bif.arvalid !== 1'b1 || bif.araddr !== 32'h1C00_0004) begin
      failures++;
      $display("FAIL two_ar1 arvalid=%b araddr=%h expected 1/1c000004", bif.arvalid, bif.araddr);
    end
    @(negedge clk);
    bif.arready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b0 || bif.arvalid !== 1'b0 || dut.r_cnt !== 2'd2) begin
        failures++;
        $display("FAIL two_full[%0d] addr_ok=%b arvalid=%b count=%0d expected 0/0/2",
                 i, bif.inst_sram_addr_ok, bif.arvalid, dut.r_cnt);
      end
      @(negedge clk);
    end
    send_r(32'hAAAA_0000, 2'b00);
    #1;
    checks++;
    if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL two_first_ret data_ok=%b addr_ok=%b expected 1/0", bif.inst_sram_data_ok, bif.inst_sram_addr_ok);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL two_third_accept got %b expected 1", bif.inst_sram_addr_ok); end
    exp_q.push_back(32'hCCCC_0008);
    @(negedge clk);
    bif.inst_sram_req = 0;
    send_r(32'hBBBB_0004, 2'b00);
    ar_accept(32'h1C00_0008);
    send_r(32'hCCCC_0008, 2'b10);
    repeat (2) @(negedge clk);
    checks++;
    if (dut.r_cnt !== 2'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL two_drain count=%0d pending=%0d expected 0/0", dut.r_cnt, exp_q.size());
    end
  endtask
  task automatic test_write_and_stray;
    bif.inst_sram_req = 1; bif.inst_sram_wr = 1; bif.inst_sram_addr = 32'h1C00_0100;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bif.inst_sram_addr_ok !== 1'b0 || bif.arvalid !== 1'b0) begin
        failures++;
        $display("FAIL write_req[%0d] addr_ok=%b arvalid=%b expected 0/0", i, bif.inst_sram_addr_ok, bif.arvalid);
      end
      @(negedge clk);
    end
    bif.inst_sram_req = 0; bif.inst_sram_wr = 0;
    bif.rvalid = 1; bif.rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bif.rready !== 1'b0) begin failures++; $display("FAIL stray_rvalid[%0d] rready=%b expected 0", i, bif.rready); end
      @(negedge clk);
    end
    bif.rvalid = 0;
  endtask
  task automatic test_mid_reset;
    bif.inst_sram_req = 1; bif.inst_sram_addr = 32'h1C00_0200;
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL midrst_accept got %b expected 1", bif.inst_sram_addr_ok); end
    @(negedge clk);
    bif.inst_sram_req = 0;
    ar_accept(32'h1C00_0200);
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    bif.rvalid = 1; bif.rdata = 32'h9999_0200;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bif.inst_sram_data_ok !== 1'b0 || bif.rready !== 1'b0 || bif.arvalid !== 1'b0 || dut.r_cnt !== 2'd0) begin
        failures++;
        $display("FAIL midrst_after[%0d] data_ok=%b rready=%b arvalid=%b count=%0d expected 0/0/0/0",
                 i, bif.inst_sram_data_ok, bif.rready, bif.arvalid, dut.r_cnt);
      end
      @(negedge clk);
    end
    bif.rvalid = 0;
  endtask
  task automatic test_simultaneous;
    bif.inst_sram_req = 1; bif.inst_sram_addr = 32'h1C00_0020;
    #1;
    checks++;
    if (bif.inst_sram_addr_ok !== 1'b1) begin failures++; $display("FAIL simul_accept0 got %b expected 1", bif.inst_sram_addr_ok); end
    exp_q.push_back(32'h3333_0020);
    @(negedge clk);
    bif.inst_sram_req = 0;
    ar_accept(32'h1C00_0020);
    send_r(32'h3333_0020, 2'b00);
    bif.inst_sram_req = 1; bif.inst_sram_addr = 32'h1C00_0024;
    #1;
    checks++;
    if (bif.inst_sram_data_ok !== 1'b1 || bif.inst_sram_addr_ok !== 1'b1 || dut.r_cnt !== 2'd1) begin
      failures++;
      $display("FAIL simul_overlap data_ok=%b addr_ok=%b count=%0d expected 1/1/1",
               bif.inst_sram_data_ok, bif.inst_sram_addr_ok, dut.r_cnt);
    end
    exp_q.push_back(32'h4444_0024);
    @(negedge clk);
    bif.inst_sram_req = 0;
    checks++;
    if (dut.r_cnt !== 2'd1 || bif.arvalid !== 1'b1 || bif.araddr !== 32'h1C00_0024) begin
      failures++;
      $display("FAIL simul_count count=%0d arvalid=%b araddr=%h expected 1/1/1c000024", dut.r_cnt, bif.arvalid, bif.araddr);
    end
    ar_accept(32'h1C00_0024);
    send_r(32'h4444_0024, 2'b00);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_two_outstanding();
    test_write_and_stray();
    test_simultaneous();
    test_mid_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover pending=%0d expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_axi_bridge.md
INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  clock; resetn  in  1  reset.
REQ-002 SHALL state: reset resetn, synchronous, active-low; clock clk.
REQ-003 SHALL have ports: inst_sram_req  in  1  fetch request; inst_sram_wr  in  1  write flag; inst_sram_size  in  2  log2 bytes; inst_sram_addr  in  32  physical address.
REQ-004 SHALL have ports: inst_sram_wstrb  in  4  unused; inst_sram_wdata  in  32  unused.
REQ-005 SHALL have ports: inst_sram_addr_ok  out  1  request accepted; inst_sram_data_ok  out  1  data returned; inst_sram_rdata  out  32  instruction word.
REQ-006 SHALL have AXI AR ports: arid  out  4; araddr  out  32; arlen  out  8; arsize  out  3; arburst  out  2; arlock  out  2; arcache  out  4; arprot  out  3; arvalid  out  1; arready  in  1.
REQ-007 SHALL have AXI R ports: rid  in  4; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.

Function
REQ-008 SHALL be read-only; a request with inst_sram_wr=1 SHALL never receive addr_ok; wstrb/wdata ignored.
REQ-009 SHALL track outstanding reads in a 2-bit counter, max 2; count = accepted requests not yet returned via data_ok.
REQ-010 SHALL run AR FSM with states IDLE and ADDR.
REQ-011 SHALL assert inst_sram_addr_ok combinationally = req & ~wr & (FSM==IDLE) & (count<2).
REQ-012 SHALL on req&addr_ok in cycle T latch addr and size, enter ADDR; arvalid=1 from T+1.
REQ-013 SHALL hold arvalid and araddr stable in ADDR until arvalid&arready, then return to IDLE next cycle; addr_ok=0 throughout ADDR.
REQ-014 SHALL drive araddr=latched addr, arsize={1'b0,latched size}, arid=0, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
REQ-015 SHALL drive rready=1 iff count!=0 and no return is pending in the output register (REQ-016).
REQ-016 SHALL capture rdata on rvalid&rready into an output register; inst_sram_data_ok=1 for exactly one cycle, the cycle after the handshake, with inst_sram_rdata = captured word.
REQ-017 SHALL hold inst_sram_rdata at its last value when data_ok=0.
REQ-018 SHALL ignore rid, rresp and rlast; an error rresp still returns data with data_ok.
REQ-019 SHALL return data strictly in request order (single ID, in-order AXI).
REQ-020 SHALL increment count on req&addr_ok and decrement on data_ok; same-cycle increment and decrement SHALL leave count unchanged.
REQ-021 SHALL allow back-to-back accepts: a new accept is possible in the cycle FSM returns to IDLE if count<2.
REQ-022 SHALL keep rready=0 when count=0; an rvalid while count=0 SHALL be left unacknowledged.
REQ-023 SHALL not enter ADDR when count=2; addr_ok stays 0 until data_ok reduces count.

Reset
REQ-024 SHALL, while resetn=0 at a clk edge, set FSM=IDLE, count=0, output register empty, araddr=0, arsize=0, inst_sram_rdata=0.
REQ-025 SHALL hold arvalid=0, rready=0, addr_ok=0, data_ok=0 while resetn=0.
REQ-026 SHALL on reset mid-transaction abandon all outstanding reads without returning data_ok for them.

Verification
REQ-027 Single fetch: req addr=0x1C000000 size=2, arready=1 at T+1, rvalid rdata=0x02800C0C at T+3 -> araddr=0x1C000000 arsize=2 at T+1, data_ok=1 rdata=0x02800C0C at T+4, count=0 at T+5.
REQ-028 AR backpressure: arready=0 for 4 cycles -> arvalid and araddr stable 4 cycles, addr_ok=0 for repeated req, accept after handshake.
REQ-029 Two outstanding: accept 0x1C000000 then 0x1C000004, no R yet -> third req addr_ok=0; R returns 0xAAAA0000 then 0xBBBB0004 -> data_ok twice, in order; third accept follows first data_ok.
REQ-030 Write request: req=1 wr=1 for 10 cycles -> addr_ok=0, arvalid=0 all cycles.
REQ-031 Mid-op reset: resetn=0 after AR handshake, before R -> data_ok never asserted, count=0, rready=0, arvalid=0 after reset.
REQ-032 Simultaneous: data_ok cycle coincides with new accept at count=1 -> count stays 1.
